// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
// Writes its result straight into the register file with a one-cycle pulse.
module div_unit #(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [XLEN-1:0]       in_src1,
    input  logic [XLEN-1:0]       in_src2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  flush,
    output logic                  busy,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [XLEN-1:0]       wdata
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [XLEN:0]         rem;
    logic [XLEN-1:0]       quo, dvs;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  op_rem, neg_q, neg_r;
    logic                  accept, sgn, s1_neg, s2_neg, div_zero, ovf, q_bit;
    logic [XLEN-1:0]       a1, a2, spec_res, quo_n, q_fin, r_fin;
    logic [XLEN:0]         shifted, trial, rem_n;
    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign accept   = in_valid && in_ready && !flush;
    assign sgn      = !in_op[0];
    assign s1_neg   = sgn && in_src1[XLEN-1];
    assign s2_neg   = sgn && in_src2[XLEN-1];
    assign a1       = s1_neg ? -in_src1 : in_src1;
    assign a2       = s2_neg ? -in_src2 : in_src2;
    assign div_zero = in_src2 == '0;
    assign ovf      = sgn && in_src1 == {1'b1, {(XLEN-1){1'b0}}} && in_src2 == '1;
    assign spec_res = in_op[1] ? (div_zero ? in_src1 : '0) : (div_zero ? '1 : in_src1);
    // Trial subtract against the shifted-in partial remainder; the extra bit is the borrow.
    assign shifted  = {rem[XLEN-1:0], quo[XLEN-1]};
    assign trial    = shifted - {1'b0, dvs};
    assign q_bit    = !trial[XLEN];
    assign rem_n    = q_bit ? trial : shifted;
    assign quo_n    = {quo[XLEN-2:0], q_bit};
    assign q_fin    = neg_q ? -quo_n : quo_n;
    assign r_fin    = neg_r ? -rem_n[XLEN-1:0] : rem_n[XLEN-1:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            rd     <= '0;
            op_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            wen    <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            wen <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    rd     <= in_rd;
                    op_rem <= in_op[1];
                    neg_q  <= s1_neg ^ s2_neg;
                    neg_r  <= s1_neg;
                    quo    <= a1;
                    dvs    <= a2;
                    rem    <= '0;
                    cnt    <= CW'(XLEN - 1);
                    state  <= (div_zero || ovf) ? DONE : CALC;
                    if (div_zero || ovf) begin
                        wen   <= in_rd != '0;
                        waddr <= in_rd;
                        wdata <= spec_res;
                    end
                end
            end else if (state == CALC) begin
                if (flush) begin
                    state <= IDLE;
                end else begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                        wen   <= rd != '0;
                        waddr <= rd;
                        wdata <= op_rem ? r_fin : q_fin;
                    end
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the RV64M DIV/DIVU/REM/REMU instructions. It sits in the execute stage, directly upstream of the register file write port. It accepts one operation through a valid/ready handshake and computes it over XLEN cycles. It then drives a single-cycle write (wen/waddr/wdata) straight into the register file.

## Interface
- XLEN, 64, operand and result width
- ADDR_WIDTH, 5, register index width; matches the register file
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- in_src1  in  XLEN  dividend
- in_src2  in  XLEN  divisor
- in_rd  in  ADDR_WIDTH  destination register index
- flush  in  1  abort the in-flight operation (pipeline redirect)
- busy  out  1  high in CALC or DONE
- wen  out  1  register file write enable, one-cycle pulse
- waddr  out  ADDR_WIDTH  destination index
- wdata  out  XLEN  quotient or remainder

## Operation
- States: IDLE, CALC, DONE.
- Handshake: the unit accepts when in_valid && in_ready && !flush. On accept it latches op, rd, sign flags and absolute operand values.
- IDLE -> CALC on accept of a normal operation.
- IDLE -> DONE on accept of a special case.
  - Divide by zero (in_src2 == 0): quotient = all ones; remainder = in_src1.
  - Signed overflow (DIV/REM, in_src1 == 1<<(XLEN-1), in_src2 == all ones): quotient = in_src1; remainder = 0.
- CALC: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Iteration counter counts XLEN-1 down to 0.
  - The partial remainder register is XLEN+1 bits, so the trial subtract never overflows.
  - CALC -> DONE after the iteration at count 0.
- Sign fixup, applied on entry to DONE for DIV/REM only:
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign.
  - DIVU/REMU use raw unsigned operands; no fixup.
- DONE: the registered wen/waddr/wdata are presented for exactly one cycle, then the unit goes DONE -> IDLE.
  - wen = 0 when rd == 0; waddr/wdata still driven.
  - wdata is the quotient for DIV/DIVU and the remainder for REM/REMU.
- flush in CALC: go to IDLE next cycle; no write.
- flush in DONE: ignored; the write completes.
- flush in IDLE: blocks acceptance.
- rst at any time: go to IDLE immediately; the in-flight operation is discarded with no write.
- Outside DONE, wen = 0. waddr and wdata hold their last values.

## Timing
- Reset values:
  - state IDLE, in_ready 1, busy 0, wen 0.
  - waddr 0, wdata 0; internal counter and datapath registers 0.
- Normal latency: accept at edge 0, CALC for edges 1..XLEN, wen high in cycle XLEN+1 (cycle 65 for XLEN = 64).
- Special-case latency: wen high in the cycle right after accept.
- in_ready goes low the cycle after accept. It returns high the cycle after DONE, so there is no back-to-back accept.
- Throughput: one operation per XLEN+2 cycles (normal) or per 2 cycles (special case).
- All outputs are registered; there are no combinational paths from inputs to wen/waddr/wdata. in_ready and busy decode state only.

## Test plan
- DIVU 100 / 7, rd = 5
  - wen = 1 exactly once, in cycle 65 after accept.
  - waddr = 5, wdata = 14.
  - in_ready = 0 throughout, 1 in cycle 66.
- DIV -7 / 2 -> wdata = -3. REM -7 / 2 -> wdata = -1. REMU 0xFFFF_FFFF_FFFF_FFFF / 16 -> wdata = 15.
- Divide by zero: DIV 5 / 0 -> wdata = 0xFFFF_FFFF_FFFF_FFFF in cycle 1 after accept. REM 5 / 0 -> wdata = 5.
- Overflow: DIV 0x8000_0000_0000_0000 / -1 -> wdata = 0x8000_0000_0000_0000. REM with the same operands -> wdata = 0. Both write in cycle 1.
- rd = 0: DIVU 9 / 3 -> wen stays 0 for the whole operation; in_ready returns after XLEN+2 cycles.
- Aborts:
  - flush at CALC cycle 10 -> no wen; in_ready = 1 in the next cycle; a new DIVU 8 / 2 then returns 4.
  - rst asserted mid-CALC -> outputs go to reset values immediately; no write.
